uart_frame_tx: RTL and testbench

// - UART transmitter serialising one FRAME_WD-bit word per request onto a single line.
// - Frame format: start bit, data bits (LSB first), optional parity bit, then stop bit(s).
// - Sits between a framing/packet controller and the chip TX pin.
// - Signals completion with a one-clock tx_done pulse.

---
 rtl/uart_frame_tx.sv | 145 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// UART transmitter: start bit, FRAME_WD data bits LSB first, optional parity, stop bit(s).
// Build option: define UART_TX_TWO_STOP_EN for two stop bits (default is one).
module uart_frame_tx #(
    parameter int unsigned CLK_FREQUENCE = 50_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter string       PARITY        = "NONE",
    parameter int unsigned FRAME_WD      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_en,
    input  logic [FRAME_WD-1:0] data_frame,
    output logic                tx_done,
    output logic                uart_tx
);

    localparam int unsigned BPS_CNT = CLK_FREQUENCE / BAUD_RATE;
    localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int unsigned BIT_W   = (FRAME_WD > 1) ? $clog2(FRAME_WD) : 1;
    localparam bit          PAR_EN  = (PARITY == "EVEN") || (PARITY == "ODD");
    localparam bit          PAR_ODD = (PARITY == "ODD");

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BPS_CNT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_WD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [FRAME_WD-1:0] shreg;
    logic                par_bit;

    logic                wrap_c;
    logic                last_stop_c;
    logic [FRAME_WD-1:0] sh_next_c;

    assign wrap_c    = (cnt == CNT_LAST);
    assign sh_next_c = shreg >> 1;

`ifdef UART_TX_TWO_STOP_EN
    logic stop_idx;
    assign last_stop_c = stop_idx;
`else
    assign last_stop_c = 1'b1;
`endif

    // Frame sequencer; the line and done pulse are driven straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
            tx_done <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_idx <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;

            if (state == S_IDLE || wrap_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // Registered pulse: set one clock early so it lands in the last stop clock.
            if (state == S_STOP && last_stop_c && cnt == CNT_PRE) begin
                tx_done <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (frame_en) begin
                        state   <= S_START;
                        shreg   <= data_frame;
                        par_bit <= PAR_ODD ? ~^data_frame : ^data_frame;
                        bit_idx <= '0;
                        uart_tx <= 1'b0;
                    end
                end
                S_START: begin
                    if (wrap_c) begin
                        state   <= S_DATA;
                        uart_tx <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (wrap_c) begin
                        if (bit_idx == BIT_LAST) begin
                            if (PAR_EN) begin
                                state   <= S_PARITY;
                                uart_tx <= par_bit;
                            end else begin
                                state   <= S_STOP;
                                uart_tx <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            shreg   <= sh_next_c;
                            uart_tx <= sh_next_c[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (wrap_c) begin
                        state   <= S_STOP;
                        uart_tx <= 1'b1;
                    end
                end
                S_STOP: begin
                    uart_tx <= 1'b1;
                    if (wrap_c) begin
`ifdef UART_TX_TWO_STOP_EN
                        if (!stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            stop_idx <= 1'b0;
                            state    <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three parity variants driven in parallel, checked against a frame-level model.
module tb_uart_frame_tx;

    localparam int unsigned CLK_F = 50_000_000;
    localparam int unsigned BAUD  = 5_000_000;
    localparam int unsigned FW    = 6;
    localparam int          BPS   = int'(CLK_F / BAUD);
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int LEN0 = (1 + FW + NSTOP) * BPS;
    localparam int LENP = LEN0 + BPS;
    localparam int HIST = 8192;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          frame_en   = 1'b0;
    logic [FW-1:0] data_frame = '0;
    logic [2:0]    tx;
    logic [2:0]    done;

    always #10 clk = ~clk;

    uart_frame_tx #(.CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD), .PARITY("NONE"), .FRAME_WD(FW)) u_none (
        .clk(clk), .rst_n(rst_n), .frame_en(frame_en), .data_frame(data_frame),
        .tx_done(done[0]), .uart_tx(tx[0]));
    uart_frame_tx #(.CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD), .PARITY("EVEN"), .FRAME_WD(FW)) u_even (
        .clk(clk), .rst_n(rst_n), .frame_en(frame_en), .data_frame(data_frame),
        .tx_done(done[1]), .uart_tx(tx[1]));
    uart_frame_tx #(.CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD), .PARITY("ODD"), .FRAME_WD(FW)) u_odd (
        .clk(clk), .rst_n(rst_n), .frame_en(frame_en), .data_frame(data_frame),
        .tx_done(done[2]), .uart_tx(tx[2]));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: per instance, a list of line levels (one per bit) and the clock position within the frame.
    int          busy[3];
    int          pos[3];
    int          nbits[3];
    logic [15:0] fbits[3];
    int          last_done[3];
    int          prev_done[3];
    bit          spacing_on = 1'b0;
    logic        tx_hist[3][0:HIST-1];

    function automatic void load(input int i, input logic [FW-1:0] d);
        int ones = 0;
        int n;
        fbits[i]    = '1;
        fbits[i][0] = 1'b0;
        n = 1;
        for (int k = 0; k < FW; k++) begin
            fbits[i][n] = d[k];
            ones = ones + int'(d[k]);
            n = n + 1;
        end
        if (i == 1) begin
            fbits[i][n] = 1'(ones % 2);
            n = n + 1;
        end else if (i == 2) begin
            fbits[i][n] = 1'((ones + 1) % 2);
            n = n + 1;
        end
        nbits[i] = n + NSTOP;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                busy[i] = 0;
                pos[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (busy[i] != 0) begin
                    if (pos[i] == nbits[i] * BPS - 1) busy[i] = 0;
                    else pos[i] = pos[i] + 1;
                end else if (frame_en) begin
                    busy[i] = 1;
                    pos[i]  = 0;
                    load(i, data_frame);
                end
            end
        end
    end

    function automatic logic exp_tx(input int i);
        if (busy[i] == 0) return 1'b1;
        return fbits[i][pos[i] / BPS];
    endfunction

    function automatic logic exp_done(input int i);
        return (busy[i] != 0) && (pos[i] == nbits[i] * BPS - 1);
    endfunction

    task automatic check(input string tag, input int i, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s inst=%0d cyc=%0d got=%b want=%b", tag, i, cyc, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int i, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", tag, i, cyc, obs, expv);
        end
    endtask

    task automatic step1();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (cyc < HIST) tx_hist[i][cyc] = tx[i];
            if (done[i] === 1'b1) begin
                if (spacing_on && prev_done[i] >= 0)
                    check_int("done_spacing", i, cyc - prev_done[i], (i == 0) ? LEN0 + 1 : LENP + 1);
                prev_done[i] = cyc;
                last_done[i] = cyc;
            end
            check("uart_tx", i, tx[i], exp_tx(i));
            check("tx_done", i, done[i], exp_done(i));
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step1();
    endtask

    task automatic wait_done(input int i, input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound && at < 0; k++) begin
            step1();
            if (done[i] === 1'b1) at = cyc;
        end
        total++;
        assert (at >= 0) else begin
            bad++;
            $error("FAIL done_timeout inst=%0d got=none want=pulse within %0d clocks", i, bound);
        end
    endtask

    initial begin
        int acc, acc2, d0, d1;
        logic [7:0] pat1;
        logic [7:0] pat2;
        pat1 = 8'b1101_0110;
        pat2 = 8'b1110_1010;
        for (int i = 0; i < 3; i++) begin
            last_done[i] = -1;
            prev_done[i] = -1;
        end

        // Reset state
        steps(3);
        for (int i = 0; i < 3; i++) begin
            check("rst_tx", i, tx[i], 1'b1);
            check("rst_done", i, done[i], 1'b0);
        end
        rst_n = 1'b1;
        steps(3);

        // Single frame 101011, data changed mid-frame, re-request right after tx_done
        data_frame = 6'b101011;
        frame_en   = 1'b1;
        step1();
        acc = cyc;
        frame_en = 1'b0;
        steps(30);
        data_frame = 6'b110101;
        wait_done(0, 100, d0);
        check_int("latency_none", 0, d0 - acc, LEN0 - 1);
        frame_en = 1'b1;
        step1();
        step1();
        acc2 = cyc;
        frame_en = 1'b0;
        check("idle_gap", 0, tx_hist[0][d0 + 1], 1'b1);
        check("start2", 0, tx_hist[0][acc2], 1'b0);
        wait_done(0, 100, d1);
        check_int("latency_2nd", 0, d1 - acc2, LEN0 - 1);
        steps(40);
        check_int("latency_even", 1, last_done[1] - acc, LENP - 1);
        check_int("latency_odd", 2, last_done[2] - acc, LENP - 1);
        for (int k = 0; k < 8; k++) begin
            check("frame1_bit", 0, tx_hist[0][acc + k * BPS + 5], pat1[k]);
            check("frame2_bit", 0, tx_hist[0][acc2 + k * BPS + 5], pat2[k]);
        end
        check("parity_even", 1, tx_hist[1][acc + 7 * BPS + 5], 1'b0);
        check("parity_odd", 2, tx_hist[2][acc + 7 * BPS + 5], 1'b1);
        check("last_stop", 0, tx_hist[0][acc + LEN0 - 1], 1'b1);

        // Asynchronous reset during the data bits
        data_frame = 6'b000000;
        frame_en   = 1'b1;
        step1();
        frame_en = 1'b0;
        steps(25);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("async_rst_tx", i, tx[i], 1'b1);
            check("async_rst_done", i, done[i], 1'b0);
        end
        steps(2);
        rst_n = 1'b1;
        steps(60);

        // frame_en held high: back-to-back frames with one idle clock
        for (int i = 0; i < 3; i++) prev_done[i] = -1;
        spacing_on = 1'b1;
        frame_en   = 1'b1;
        for (int k = 0; k < 400; k++) begin
            data_frame = FW'($urandom);
            step1();
        end
        spacing_on = 1'b0;
        frame_en   = 1'b0;
        steps(120);

        // Random requests and data
        for (int k = 0; k < 1500; k++) begin
            frame_en   = ($urandom_range(0, 7) == 0);
            data_frame = FW'($urandom);
            step1();
        end
        frame_en = 1'b0;
        steps(120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
